// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst types, response codes and transfer-size helper.
// Used by both the core master bridge and the AXI RAM slave.
package axi_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  // AxSIZE encoding for a beat of the given byte width.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_core_master.sv
// Single-outstanding core load/store port to AXI4 master bridge.
// Issues one single-beat INCR read or write at a time; all AXI/rsp outputs are registered.
module axi_core_master
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASTER_ID  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  axi_if.m                        axi_m
);

  localparam int unsigned           StrbW    = DATA_WIDTH / 8;
  localparam logic [2:0]            AxSize   = axi_size(StrbW);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'(StrbW - 1);

  typedef enum logic [2:0] {
    StIdle, StWrite, StWresp, StRaddr, StRdata, StRdrain, StResp
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic                    aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    ar_valid_q, ar_valid_d, b_ready_q, b_ready_d, r_ready_q, r_ready_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ar_valid_d  = ar_valid_q;
    b_ready_d   = b_ready_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr & AddrMask;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = StWrite;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = StRaddr;
          end
        end
      end
      StWrite: begin
        // AW and W complete independently, in either order or together.
        if (aw_valid_q && axi_m.awready) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && axi_m.wready) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          state_d   = StWresp;
        end
      end
      StWresp: begin
        if (axi_m.bvalid) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (axi_m.bresp != RespOkay);
          rsp_rdata_d = '0;
          state_d     = StResp;
        end
      end
      StRaddr: begin
        if (axi_m.arready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = StRdata;
        end
      end
      StRdata: begin
        // A multi-beat reply is a protocol error; keep the first beat, drain the rest.
        if (axi_m.rvalid) begin
          rsp_rdata_d = axi_m.rdata;
          rsp_err_d   = (axi_m.rresp != RespOkay) || !axi_m.rlast;
          if (axi_m.rlast) begin
            r_ready_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            state_d = StRdrain;
          end
        end
      end
      StRdrain: begin
        if (axi_m.rvalid && axi_m.rlast) begin
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ar_valid_q  <= ar_valid_d;
      b_ready_q   <= b_ready_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign axi_m.awid    = ID_WIDTH'(MASTER_ID);
  assign axi_m.awaddr  = addr_q;
  assign axi_m.awlen   = 8'd0;
  assign axi_m.awsize  = AxSize;
  assign axi_m.awburst = BurstIncr;
  assign axi_m.awvalid = aw_valid_q;
  assign axi_m.wdata   = wdata_q;
  assign axi_m.wstrb   = wstrb_q;
  assign axi_m.wlast   = 1'b1;
  assign axi_m.wvalid  = w_valid_q;
  assign axi_m.bready  = b_ready_q;
  assign axi_m.arid    = ID_WIDTH'(MASTER_ID);
  assign axi_m.araddr  = addr_q;
  assign axi_m.arlen   = 8'd0;
  assign axi_m.arsize  = AxSize;
  assign axi_m.arburst = BurstIncr;
  assign axi_m.arvalid = ar_valid_q;
  assign axi_m.rready  = r_ready_q;

  // Response IDs are irrelevant with a single transaction in flight.
  logic unused_ids;
  assign unused_ids = ^{axi_m.bid, axi_m.rid};

endmodule

// File: tb/tb_axi_core_master.sv
// Scoreboard bench for axi_core_master: directed core requests against a scripted AXI slave.
module tb_axi_core_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  axi_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_core_master #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASTER_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_m(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, req_cyc = 0, rsp_lat = 0, b_cnt = 0;
  bit          rsp_seen = 1'b0;
  logic [31:0] aw_q[$], ar_q[$];
  logic [35:0] w_q[$];
  rsp_t        rsp_q[$];
  rsp_t        exp_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake with no expected entry (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: all DUT outputs are registered and the bench drives only at posedge+1,
  // so a negedge sample shows exactly what the next edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.awvalid && bus.awready) begin
        if (aw_q.size() == 0) unexpected("aw");
        else check("aw_fields", {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                   {4'd0, aw_q.pop_front(), 8'd0, 3'd2, 2'b01});
      end
      if (bus.wvalid && bus.wready) begin
        if (w_q.size() == 0) unexpected("w");
        else check("w_fields", {bus.wdata, bus.wstrb, bus.wlast}, {w_q.pop_front(), 1'b1});
      end
      if (bus.arvalid && bus.arready) begin
        if (ar_q.size() == 0) unexpected("ar");
        else check("ar_fields", {bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst},
                   {4'd0, ar_q.pop_front(), 8'd0, 3'd2, 2'b01});
      end
      if (bus.awvalid || bus.wvalid) check("bready_early", bus.bready, 1'b0);
      if (bus.bvalid && bus.bready) b_cnt++;
      if (req_valid && req_ready) begin
        req_cyc  = cyc;
        rsp_seen = 1'b0;
      end
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1'b1;
        rsp_lat  = cyc - req_cyc;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) unexpected("rsp");
        else begin
          exp_r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, exp_r.rdata);
          check("rsp_err", rsp_err, exp_r.err);
          if (exp_r.lat >= 0) check("rsp_latency", rsp_lat, exp_r.lat);
        end
      end
    end
  end

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int   n = 0;
    logic rdy;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; req_wstrb = strb;
    do begin
      rdy = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 50);
    check("req_accept", rdy, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic aw_slave(input int dly);
    int n = 0;
    while (!bus.awvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("aw_start", bus.awvalid, 1'b1);
    if (!bus.awvalid) return;
    for (int i = 0; i < dly; i++) begin @(posedge clk); #1; check("aw_hold", bus.awvalid, 1'b1); end
    bus.awready = 1'b1;
    @(posedge clk); #1;
    bus.awready = 1'b0;
    check("aw_drop", bus.awvalid, 1'b0);
  endtask

  task automatic w_slave(input int dly);
    int n = 0;
    while (!bus.wvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("w_start", bus.wvalid, 1'b1);
    if (!bus.wvalid) return;
    for (int i = 0; i < dly; i++) begin @(posedge clk); #1; check("w_hold", bus.wvalid, 1'b1); end
    bus.wready = 1'b1;
    @(posedge clk); #1;
    bus.wready = 1'b0;
    check("w_drop", bus.wvalid, 1'b0);
  endtask

  task automatic ar_slave(input int dly);
    int n = 0;
    while (!bus.arvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("ar_start", bus.arvalid, 1'b1);
    if (!bus.arvalid) return;
    for (int i = 0; i < dly; i++) begin @(posedge clk); #1; check("ar_hold", bus.arvalid, 1'b1); end
    bus.arready = 1'b1;
    @(posedge clk); #1;
    bus.arready = 1'b0;
    check("ar_drop", bus.arvalid, 1'b0);
  endtask

  // early=1 raises BVALID before the write handshakes; it must not be accepted yet.
  task automatic b_slave(input logic [1:0] resp, input bit early);
    int n = 0;
    if (early) begin bus.bvalid = 1'b1; bus.bresp = resp; end
    while (!bus.bready && n < 50) begin @(posedge clk); #1; n++; end
    check("b_start", bus.bready, 1'b1);
    bus.bvalid = 1'b1; bus.bresp = resp;
    @(posedge clk); #1;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    check("b_drop", bus.bready, 1'b0);
  endtask

  task automatic r_slave(input logic [31:0] d0, input int beats, input logic [1:0] resp);
    int n = 0;
    while (!bus.rready && n < 50) begin @(posedge clk); #1; n++; end
    check("r_start", bus.rready, 1'b1);
    for (int i = 0; i < beats; i++) begin
      if (i > 0) check("r_ready_hold", bus.rready, 1'b1);
      bus.rvalid = 1'b1; bus.rdata = d0 + 32'(i); bus.rresp = resp; bus.rlast = (i == beats - 1);
      @(posedge clk); #1;
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
    check("r_drop", bus.rready, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !rsp_valid) && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_reached", req_ready && !rsp_valid, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [31:0] data, input logic [3:0] strb, input int aw_dly,
                          input int w_dly, input logic [1:0] bresp, input bit early,
                          input logic exp_err, input int lat);
    wait_idle();
    aw_q.push_back(exp_addr);
    w_q.push_back({data, strb});
    rsp_q.push_back('{32'h0, exp_err, lat});
    fork
      send_req(1'b1, addr, data, strb);
      aw_slave(aw_dly);
      w_slave(w_dly);
      b_slave(bresp, early);
    join
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] d0, input int beats, input logic [1:0] rresp,
                         input int ar_dly, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat);
    wait_idle();
    ar_q.push_back(exp_addr);
    rsp_q.push_back('{exp_rdata, exp_err, lat});
    fork
      send_req(1'b0, addr, 32'h0, 4'h0);
      ar_slave(ar_dly);
      r_slave(d0, beats, rresp);
    join
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valids"}, {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                              rsp_valid, rsp_err}, 7'b0);
    check({name, "_req_ready"}, req_ready, 1'b1);
    check({name, "_regs"}, {rsp_rdata, bus.awaddr}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = '0;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = '0;
    #12;
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_write(32'h10, 32'h10, 32'h1234_5678, 4'hF, 0, 0, 2'b00, 1'b0, 1'b0, 3);
    do_write(32'h20, 32'h20, 32'hA1B2_C3D4, 4'hF, 3, 0, 2'b00, 1'b1, 1'b0, -1);
    do_write(32'h36, 32'h34, 32'h0BAD_F00D, 4'hC, 0, 3, 2'b00, 1'b0, 1'b0, -1);
    do_read(32'h13, 32'h10, 32'hDEAD_BEEF, 1, 2'b00, 0, 32'hDEAD_BEEF, 1'b0, 3);
    do_read(32'h40, 32'h40, 32'h1111_0000, 1, 2'b10, 2, 32'h1111_0000, 1'b1, -1);
    do_write(32'h50, 32'h50, 32'hFFFF_0000, 4'h3, 0, 0, 2'b11, 1'b0, 1'b1, 3);
    do_read(32'h60, 32'h60, 32'h5555_0000, 3, 2'b00, 0, 32'h5555_0000, 1'b1, -1);

    // Response back-pressure: response must hold steady while rsp_ready is low.
    wait_idle();
    rsp_ready = 1'b0;
    do_read(32'h44, 32'h44, 32'hA5A5_0001, 1, 2'b00, 0, 32'hA5A5_0001, 1'b0, 3);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hA5A5_0001});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", rsp_valid, 1'b0);

    // Reset in the middle of a write the slave never accepts: no completion may follow.
    wait_idle();
    send_req(1'b1, 32'h70, 32'h7777_7777, 4'hF);
    @(posedge clk); #1;
    check("abort_pending", {bus.awvalid, bus.wvalid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_quiet("abort_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_quiet("abort_after");
    end

    do_read(32'h7C, 32'h7C, 32'h0F0F_0F0F, 1, 2'b00, 0, 32'h0F0F_0F0F, 1'b0, 3);
    wait_idle();
    @(posedge clk); #1;
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("addr_queues_empty", aw_q.size() + ar_q.size() + w_q.size(), 0);
    check("b_handshakes", b_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_core_master.md
Name: axi_core_master

Overview:
- Bridges a simple single-outstanding core memory port (load/store unit) to the AXI4 master side of the system interconnect.
- Drives the same AXI channel set consumed by the AXI RAM slave.
- Issues single-beat INCR transactions only: one read or one write in flight, response returned to the core on a valid/ready handshake.

Parameters:
ID_WIDTH, 4, width of AWID/ARID/BID/RID
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; multiple of 8, power of two
MASTER_ID, 0, constant driven on AWID/ARID

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  write data
req_wstrb  input  DATA_WIDTH/8  write byte enables
rsp_valid  output  1  response valid, held until rsp_ready
rsp_ready  input  1  core accepts response
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  SLVERR/DECERR or protocol error
axi_m  interface  axi_if.m  AXI4 master: AW, W, B, AR, R channels

Behaviour:
- Reset (async assert, sync deassert): state IDLE; req_ready=1; AWVALID=WVALID=ARVALID=BREADY=RREADY=rsp_valid=rsp_err=0; rsp_rdata=0; address/data registers 0. Reset mid-transaction abandons it; no completion is issued.
- All AXI and rsp outputs come from registers (no combinational input-to-output paths), except req_ready, which is high exactly in IDLE.
- Constant fields: AxLEN=0, AxSIZE=clog2(DATA_WIDTH/8), AxBURST=2'b01, AxID=MASTER_ID, WLAST=1.
- AxADDR = req_addr with the low clog2(DATA_WIDTH/8) bits cleared; byte selection is done only by WSTRB.
- States:
  - IDLE: on request handshake, capture addr/wdata/wstrb. If req_we=1, go to WRITE, AWVALID=1 and WVALID=1 next cycle. If req_we=0, go to RADDR, ARVALID=1 next cycle.
  - WRITE: aw_done and w_done flags track each channel independently. AWVALID drops the cycle after AWREADY; WVALID drops the cycle after WREADY; the handshakes may complete in either order or in the same cycle. When both are done, go to WRESP and set BREADY=1. VALID is never withdrawn before its READY.
  - WRESP: on BVALID&BREADY, set rsp_err = (BRESP!=2'b00), rsp_rdata=0, BREADY=0, rsp_valid=1, then go to RESP. A BVALID arriving before both AW and W handshakes is ignored (BREADY stays 0).
  - RADDR: on ARREADY, drop ARVALID, set RREADY=1, go to RDATA.
  - RDATA: on the first RVALID beat, capture RDATA and err = (RRESP!=2'b00) | !RLAST. If RLAST=1, go to RESP with rsp_valid=1. If RLAST=0, go to RDRAIN.
  - RDRAIN: RREADY=1; discard beats until a beat with RLAST=1; then rsp_valid=1 and go to RESP.
  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable. On rsp_ready, drop rsp_valid and return to IDLE; the next request can be accepted the following cycle.
- Minimum latency with zero-wait slave: request handshake at cycle N, AW/W handshakes at N+1, B at N+2, rsp_valid at N+3. Reads follow the same timing.
- BID/RID are not checked; with a single outstanding transaction they are not needed.

Decomposition:
- Shared package axi_pkg: burst type enum (FIXED/INCR/WRAP), response codes (OKAY/EXOKAY/SLVERR/DECERR), function for AxSIZE from byte width. The RAM slave uses the same package.
- FSM state enum is local to the module.
- No sub-module: single FSM with two channel-done flags.

Test Plan:
- Write 0x1234_5678, addr 0x10, wstrb 0xF; slave with AWREADY=WREADY=1, BRESP=0 -> AWADDR=0x10, AWLEN=0, AWSIZE=2, WLAST=1; rsp_valid at N+3 with rsp_err=0.
- Write where WREADY comes 3 cycles before AWREADY, then the reverse order -> each VALID drops one cycle after its own handshake; exactly one B accepted; one response.
- Read addr 0x13, slave returns RDATA 0xDEADBEEF, RLAST=1, RRESP=0 -> ARADDR=0x10; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read with RRESP=2'b10 -> rsp_err=1. Write with BRESP=2'b11 -> rsp_err=1, rsp_rdata=0.
- Read where slave sends 3 beats, RLAST only on the last -> first beat captured, rsp_err=1, RREADY held through the third beat, single response.
- rsp_ready held low 5 cycles, then rst_n pulsed low during a later pending write -> response stable all 5 cycles; after reset all valids=0, req_ready=1, no stale rsp_valid.
